// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
// Segments are active-low; the table entries all have the point segment off.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         SEG_A_BIT = 7;
    localparam int         SEG_P_BIT = 0;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + point to active-low segment pattern {a..g,p}.
// Zero latency; no flow control.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] segment
);

    always_comb begin
        segment            = hex_to_seg(nibble);
        segment[SEG_P_BIT] = ~point;
    end

endmodule

// File: rtl/seg7_scan_dev.sv
// Self-scanning, double-buffered common-anode display driver; loads commit at frame wrap.
// Outputs are registered one clock behind the scan index; load is always accepted (last wins).
module seg7_scan_dev
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 17,
    parameter int BLINK_DIV = 24
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   disp_num,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     les,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lzs,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            segment,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = 7*DIGITS + 1;

    logic [SCAN_DIV-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic                 running_q,   running_d;
    logic [WORD_W-1:0]    pend_q,      pend_d;
    logic [WORD_W-1:0]    act_q,       act_d;
    logic                 pending_q,   pending_d;
    logic                 wrap_q,      wrap_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]    an_q,        an_d;
    logic [7:0]           segment_q,   segment_d;

    logic [4*DIGITS-1:0]  act_num;
    logic [DIGITS-1:0]    act_pt, act_les, act_blk, sup;
    logic                 act_lzs, zero_run;
    logic                 scan_tick, boundary, blanked;
    logic [3:0]           cur_nib;
    logic [7:0]           dec_seg;

    assign act_num = act_q[4*DIGITS-1:0];
    assign act_pt  = act_q[5*DIGITS-1:4*DIGITS];
    assign act_les = act_q[6*DIGITS-1:5*DIGITS];
    assign act_blk = act_q[7*DIGITS-1:6*DIGITS];
    assign act_lzs = act_q[7*DIGITS];

    assign scan_tick = &scan_cnt_q;
    assign boundary  = scan_tick && running_q && (idx_q == IDX_W'(DIGITS-1));
    assign cur_nib   = 4'(act_num >> {idx_q, 2'b00});
    assign blanked   = act_les[idx_q] | (act_blk[idx_q] & blink_cnt_q[BLINK_DIV-1]);

    seg7_hex_decode u_dec (
        .nibble  (cur_nib),
        .point   (act_pt[idx_q]),
        .segment (dec_seg)
    );

    // A digit is suppressed when it and every more significant nibble are zero.
    always_comb begin
        zero_run = 1'b1;
        sup      = '0;
        for (int i = DIGITS-1; i > 0; i--) begin
            zero_run = zero_run & (act_num[4*i +: 4] == 4'd0);
            sup[i]   = act_lzs & zero_run;
        end
    end

    always_comb begin
        scan_cnt_d   = scan_cnt_q + 1'b1;
        blink_cnt_d  = blink_cnt_q + 1'b1;
        idx_d        = idx_q;
        running_d    = running_q;
        pend_d       = pend_q;
        act_d        = act_q;
        pending_d    = pending_q;
        wrap_d       = boundary;
        frame_tick_d = wrap_q;
        an_d         = '1;
        segment_d    = SEG_BLANK;

        // The first tick after reset only starts the scan at digit 0.
        if (scan_tick) begin
            running_d = 1'b1;
            if (!running_q || boundary) idx_d = '0;
            else                        idx_d = idx_q + 1'b1;
        end

        if (boundary && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_d    = {lzs, blink, les, point, disp_num};
            pending_d = 1'b1;
        end

        if (running_q && !blanked) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (sup[idx_q]) begin
                segment_d            = SEG_BLANK;
                segment_d[SEG_P_BIT] = ~act_pt[idx_q];
            end else begin
                segment_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            idx_q        <= '0;
            running_q    <= 1'b0;
            pend_q       <= '0;
            act_q        <= '0;
            pending_q    <= 1'b0;
            wrap_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= '1;
            segment_q    <= SEG_BLANK;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            idx_q        <= idx_d;
            running_q    <= running_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            pending_q    <= pending_d;
            wrap_q       <= wrap_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            segment_q    <= segment_d;
        end
    end

    assign AN         = an_q;
    assign segment    = segment_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_dev.sv
// Bench for seg7_scan_dev (DIGITS=4, SCAN_DIV=2, BLINK_DIV=5): cycle-count reference model plus literal checks.
`timescale 1ns/1ps
module tb_seg7_scan_dev;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n, load, lzs;
    logic [15:0] disp_num;
    logic [3:0]  point, les, blink;
    logic [3:0]  AN;
    logic [7:0]  segment;
    logic        frame_tick, pending;

    seg7_scan_dev #(.DIGITS(D), .SCAN_DIV(2), .BLINK_DIV(5)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .disp_num(disp_num),
        .point(point), .les(les), .blink(blink), .lzs(lzs),
        .AN(AN), .segment(segment), .frame_tick(frame_tick), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lzs;
        logic [3:0] blk;
        logic [3:0] les;
        logic [3:0] pt;
        logic [15:0] num;
    } word_t;

    localparam logic [7:0] HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    int    tests = 0;
    int    fails = 0;
    int    mk = 0;
    word_t m_act, m_pend;
    bit    m_pending;
    bit    chk_en = 0;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft, e_pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: mk counts clocks since reset release. Slot s=mk/4-1 shows digit s%4,
    // a frame wrap happens on clock mk where mk%16==4 (mk>=20), blink phase is mk%32>=16.
    always @(posedge clk) begin
        int  kk;
        int  d;
        bit  ph;
        chk_en = 1;
        if (!rst_n) begin
            mk = 0; m_act = '0; m_pend = '0; m_pending = 0;
            e_an = 4'hF; e_seg = 8'hFF; e_ft = 0; e_pend = 0;
        end else begin
            kk = mk;
            e_an = 4'hF; e_seg = 8'hFF;
            if (kk >= 4) begin
                d  = (kk/4 - 1) % 4;
                ph = (kk % 32) >= 16;
                if (!(m_act.les[d] || (m_act.blk[d] && ph))) begin
                    e_an[d] = 1'b0;
                    if (m_act.lzs && d > 0 && (m_act.num >> (4*d)) == 16'd0) begin
                        e_seg = 8'hFF;
                    end else begin
                        e_seg = HEX[m_act.num[4*d +: 4]];
                    end
                    e_seg[0] = ~m_act.pt[d];
                end
            end
            e_ft = (kk % 16 == 4) && (kk >= 20);
            mk = mk + 1;
            if ((mk % 16 == 4) && (mk >= 20) && m_pending) begin
                m_act = m_pend;
                m_pending = 0;
            end
            if (load) begin
                m_pend = {lzs, blink, les, point, disp_num};
                m_pending = 1;
            end
            e_pend = m_pending;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 32'(AN), 32'(e_an));
            check("segment", 32'(segment), 32'(e_seg));
            check("frame_tick", 32'(frame_tick), 32'(e_ft));
            check("pending", 32'(pending), 32'(e_pend));
        end
    end

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait expired, got no event expected event at %0t", name, $time);
    endtask

    task automatic wait_digit(input int d);
        logic [3:0] want;
        int n;
        want = 4'hF;
        want[d] = 1'b0;
        n = 0;
        while (AN !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_digit");
    endtask

    task automatic expect_frame(input string name, input logic [31:0] segs);
        for (int d = 0; d < D; d++) begin
            wait_digit(d);
            check(name, 32'(segment), 32'(segs[8*d +: 8]));
        end
    endtask

    task automatic do_load(input word_t w);
        disp_num = w.num; point = w.pt; les = w.les; blink = w.blk; lzs = w.lzs;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("wait_idle");
    endtask

    task automatic wait_mk(input int phase);
        int n = 0;
        while (!(mk >= 20 && mk % 16 == phase) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_mk");
    endtask

    initial begin
        int n, cnt2, cnt0;
        rst_n = 0; load = 0; disp_num = '0; point = '0; les = '0; blink = '0; lzs = 0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(AN), 32'h0000_000F);
        check("rst_seg", 32'(segment), 32'h0000_00FF);
        check("rst_pend", 32'(pending), 32'h0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("pre_tick_an", 32'(AN), 32'h0000_000F);
        expect_frame("reset_frame", 32'h03030303);

        do_load('{lzs: 1'b0, blk: 4'h0, les: 4'h0, pt: 4'b0010, num: 16'h1A08});
        check("pend_rise", 32'(pending), 32'h1);
        wait_idle();
        expect_frame("load_1A08", 32'h9F110201);

        do_load('{lzs: 1'b0, blk: 4'h0, les: 4'h0, pt: 4'h0, num: 16'h1111});
        @(negedge clk);
        wait_mk(3);
        do_load('{lzs: 1'b0, blk: 4'h0, les: 4'h0, pt: 4'h0, num: 16'h2222});
        check("pend_hold", 32'(pending), 32'h1);
        expect_frame("sim_1111", 32'h9F9F9F9F);
        expect_frame("sim_2222", 32'h25252525);

        do_load('{lzs: 1'b1, blk: 4'h0, les: 4'h0, pt: 4'h0, num: 16'h0040});
        wait_idle();
        expect_frame("lzs_0040", 32'hFFFF9903);
        do_load('{lzs: 1'b1, blk: 4'h0, les: 4'h0, pt: 4'h0, num: 16'h0000});
        wait_idle();
        expect_frame("lzs_0000", 32'hFFFFFF03);

        do_load('{lzs: 1'b0, blk: 4'b0001, les: 4'b0100, pt: 4'h0, num: 16'h0000});
        wait_idle();
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_frame");
        cnt2 = 0; cnt0 = 0;
        for (int c = 0; c < 128; c++) begin
            if (AN[2] === 1'b0) cnt2++;
            if (AN === 4'hE) cnt0++;
            @(negedge clk);
        end
        check("les_an2_low", 32'(cnt2), 32'd0);
        check("blink_lit", 32'(cnt0), 32'd16);

        for (int c = 0; c < 1500; c++) begin
            rst_n    = ($urandom % 300) != 0;
            load     = ($urandom % 12) == 0;
            disp_num = 16'($urandom) >> (4 * $urandom_range(0, 3));
            point    = 4'($urandom);
            les      = 4'($urandom & $urandom & $urandom);
            blink    = 4'($urandom);
            lzs      = 1'($urandom);
            @(negedge clk);
        end
        rst_n = 1; load = 0;

        wait_mk(5);
        do_load('{lzs: 1'b0, blk: 4'h0, les: 4'h0, pt: 4'hF, num: 16'h5678});
        wait_mk(10);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("mid_rst_pend", 32'(pending), 32'h0);
        n = 0;
        while (AN === 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_scan");
        check("mid_rst_idx", 32'(AN), 32'h0000_000E);
        expect_frame("mid_rst_frame", 32'h03030303);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
